// File: rtl/uart_rx_bit_timer.sv
// UART RX bit timer: per-bit oversampling counters, mid-bit sample strobes,
// bit/frame end strobes. Frame format and prescale are latched at frame start.
module uart_rx_bit_timer #(
    parameter int unsigned PRESCALE_W    = 6,
    parameter int unsigned BIT_CNT_W     = 4,
    parameter int unsigned MAX_DATA_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  two_stop,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sample_stb,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [PRESCALE_W-1:0] mid_q, mid_d;
    logic [BIT_CNT_W-1:0]  flen_q, flen_d;
    logic                  cfg_err_q, cfg_err_d;
    // Set on a rejected config; blocks retry until enable drops or restart.
    logic                  lock_q, lock_d;

    logic                  cfg_ok;
    logic [BIT_CNT_W-1:0]  flen_in;
    logic                  last_edge;
    logic                  last_bit;

    // Validate incoming configuration and derive the frame length.
    always_comb begin
        flen_in = BIT_CNT_W'(data_bits) + BIT_CNT_W'(par_en)
                + BIT_CNT_W'(two_stop) + BIT_CNT_W'(2);
        cfg_ok  = (prescale >= PRESCALE_W'(4))
               && (data_bits >= 4'd5)
               && (data_bits <= 4'(MAX_DATA_BITS));
    end

    // Output decode from registered counters and latched configuration.
    always_comb begin
        busy       = (state_q == RUN);
        last_edge  = (edge_q == p_q - PRESCALE_W'(1));
        last_bit   = (bit_q == flen_q - BIT_CNT_W'(1));
        bit_done   = busy && last_edge;
        frame_done = bit_done && last_bit;
        sample_stb = busy && ((edge_q == mid_q - PRESCALE_W'(1))
                           || (edge_q == mid_q)
                           || (edge_q == mid_q + PRESCALE_W'(1)));
        edge_cnt   = edge_q;
        bit_cnt    = bit_q;
        cfg_err    = cfg_err_q;
    end

    // Next-state logic: restart beats enable; enable low aborts but keeps cfg_err.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        mid_d     = mid_q;
        flen_d    = flen_q;
        cfg_err_d = cfg_err_q;
        lock_d    = lock_q;

        if (restart) begin
            state_d   = IDLE;
            edge_d    = '0;
            bit_d     = '0;
            cfg_err_d = 1'b0;
            lock_d    = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
            edge_d  = '0;
            bit_d   = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    edge_d = '0;
                    bit_d  = '0;
                    if (!lock_q) begin
                        if (cfg_ok) begin
                            p_d     = prescale;
                            mid_d   = prescale >> 1;
                            flen_d  = flen_in;
                            state_d = RUN;
                        end else begin
                            cfg_err_d = 1'b1;
                            lock_d    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_edge) begin
                        edge_d = '0;
                        if (last_bit) begin
                            bit_d   = '0;
                            state_d = IDLE;
                        end else begin
                            bit_d = bit_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        edge_d = edge_q + PRESCALE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= '0;
            mid_q     <= '0;
            flen_q    <= '0;
            cfg_err_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            mid_q     <= mid_d;
            flen_q    <= flen_d;
            cfg_err_q <= cfg_err_d;
            lock_q    <= lock_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: frame-level reference model,
// table-driven frame configurations, directed corner sequences, random traffic.
module tb_uart_rx_bit_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [3:0] data_bits = 4'd8;
    logic       par_en = 1'b0;
    logic       two_stop = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_stb, bit_done, frame_done, busy, cfg_err;

    int errors = 0;
    int checks = 0;

    uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4), .MAX_DATA_BITS(9)) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .prescale(prescale), .data_bits(data_bits), .par_en(par_en),
        .two_stop(two_stop), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .sample_stb(sample_stb), .bit_done(bit_done), .frame_done(frame_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is P*frame_len consecutive RUN cycles indexed by t.
    int m_run = 0, m_t = 0, m_p = 0, m_flen = 0, m_err = 0, m_lock = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_p = 0; m_flen = 0; m_err = 0; m_lock = 0;
    endtask

    task automatic model_step();
        int db;
        db = int'(data_bits);
        if (rst) model_reset();
        else if (restart) begin
            m_run = 0; m_t = 0; m_err = 0; m_lock = 0;
        end else if (!enable) begin
            m_run = 0; m_t = 0; m_lock = 0;
        end else if (m_run != 0) begin
            if (m_t == m_p * m_flen - 1) begin
                m_run = 0; m_t = 0;
            end else m_t++;
        end else if (m_lock == 0) begin
            if (int'(prescale) >= 4 && db >= 5 && db <= 9) begin
                m_p = int'(prescale);
                m_flen = 2 + db + int'(par_en) + int'(two_stop);
                m_run = 1; m_t = 0;
            end else begin
                m_err = 1; m_lock = 1;
            end
        end
    endtask

    task automatic model_compare();
        int e, b, mid, s, bd, fd;
        e = 0; b = 0; s = 0; bd = 0; fd = 0;
        if (m_run != 0) begin
            e   = m_t % m_p;
            b   = m_t / m_p;
            mid = m_p / 2;
            s   = (e + 1 == mid || e == mid || e == mid + 1) ? 1 : 0;
            bd  = (e == m_p - 1) ? 1 : 0;
            fd  = (m_t == m_p * m_flen - 1) ? 1 : 0;
        end
        chk("edge_cnt", int'(edge_cnt), e);
        chk("bit_cnt", int'(bit_cnt), b);
        chk("sample_stb", int'(sample_stb), s);
        chk("bit_done", int'(bit_done), bd);
        chk("frame_done", int'(frame_done), fd);
        chk("busy", int'(busy), m_run);
        chk("cfg_err", int'(cfg_err), m_err);
    endtask

    // One clock: model sees the inputs the DUT sampled, then outputs are compared.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_compare();
    endtask

    typedef struct {
        logic [5:0] prescale;
        logic [3:0] data_bits;
        logic       par_en;
        logic       two_stop;
        int         exp_run_cycles;
        int         exp_first_sample;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, first_s, last_bd, cyc, guard;

        vecs[0] = '{6'd8,  4'd8, 1'b0, 1'b0, 80,  3,  0};
        vecs[1] = '{6'd16, 4'd7, 1'b1, 1'b1, 176, 7,  0};
        vecs[2] = '{6'd5,  4'd5, 1'b0, 1'b0, 35,  1,  0};
        vecs[3] = '{6'd4,  4'd9, 1'b1, 1'b1, 52,  1,  0};
        vecs[4] = '{6'd63, 4'd9, 1'b1, 1'b1, 819, 30, 0};
        vecs[5] = '{6'd8,  4'd10, 1'b0, 1'b0, 0,  0,  1};

        // Reset state
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_edge", int'(edge_cnt), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        cycle();
        rst = 1'b0;
        cycle();

        // Table-driven frame configurations
        foreach (vecs[i]) begin
            prescale  = vecs[i].prescale;
            data_bits = vecs[i].data_bits;
            par_en    = vecs[i].par_en;
            two_stop  = vecs[i].two_stop;
            restart   = 1'b1;
            enable    = 1'b1;
            cycle();
            restart = 1'b0;
            n = 0; first_s = -1; guard = 0;
            if (vecs[i].exp_err != 0) begin
                repeat (5) begin
                    cycle();
                    if (busy) n++;
                end
                chk("tbl_err_flag", int'(cfg_err), 1);
                chk("tbl_err_busy_cycles", n, 0);
            end else begin
                do begin
                    cycle();
                    guard++;
                    if (busy) n++;
                    if (sample_stb && first_s < 0) first_s = int'(edge_cnt);
                end while (!frame_done && guard < 2000);
                chk("tbl_frame_done_seen", int'(frame_done), 1);
                chk("tbl_run_cycles", n, vecs[i].exp_run_cycles);
                chk("tbl_first_sample", first_s, vecs[i].exp_first_sample);
                chk("tbl_last_bit_cnt", int'(bit_cnt),
                    2 + int'(vecs[i].data_bits) + int'(vecs[i].par_en) + int'(vecs[i].two_stop) - 1);
                cycle();
                chk("tbl_gap_busy", int'(busy), 0);
            end
        end

        // Invalid prescale, retry lockout, recovery via restart
        restart = 1'b1; cycle(); restart = 1'b0;
        prescale = 6'd3; data_bits = 4'd8; par_en = 1'b0; two_stop = 1'b0;
        enable = 1'b1;
        repeat (3) cycle();
        chk("err_p3_cfg_err", int'(cfg_err), 1);
        chk("err_p3_busy", int'(busy), 0);
        prescale = 6'd8;
        repeat (3) cycle();
        chk("err_locked_busy", int'(busy), 0);
        restart = 1'b1; cycle(); restart = 1'b0;
        chk("err_cleared", int'(cfg_err), 0);
        repeat (2) cycle();
        chk("err_recover_busy", int'(busy), 1);

        // Prescale change mid-frame does not affect the running frame
        restart = 1'b1; cycle(); restart = 1'b0;
        prescale = 6'd8;
        guard = 0;
        do begin cycle(); guard++; end while (!(busy && bit_cnt == 4'd4) && guard < 200);
        chk("chg_reach_bit4", int'(bit_cnt), 4);
        prescale = 6'd16;
        last_bd = -1; cyc = 0; guard = 0;
        do begin
            cycle(); cyc++; guard++;
            if (bit_done) begin
                if (last_bd >= 0) chk("chg_bit_spacing", cyc - last_bd, 8);
                last_bd = cyc;
            end
        end while (!frame_done && guard < 200);
        chk("chg_frame_done_seen", int'(frame_done), 1);
        n = 0; guard = 0;
        do begin
            cycle(); guard++;
            if (busy) n++;
        end while (!frame_done && guard < 400);
        chk("chg_next_frame_cycles", n, 160);

        // Restart mid-bit with enable still high
        restart = 1'b1; cycle(); restart = 1'b0;
        prescale = 6'd8;
        guard = 0;
        do begin cycle(); guard++; end
        while (!(busy && bit_cnt == 4'd5 && edge_cnt == 6'd6) && guard < 200);
        chk("rs_reach_point", int'(edge_cnt), 6);
        restart = 1'b1; cycle(); restart = 1'b0;
        chk("rs_edge", int'(edge_cnt), 0);
        chk("rs_bit", int'(bit_cnt), 0);
        chk("rs_idle", int'(busy), 0);
        cycle();
        chk("rs_run", int'(busy), 1);
        chk("rs_run_edge", int'(edge_cnt), 0);

        // Asynchronous reset mid-bit clears with no clock edge
        repeat (13) cycle();
        #3 rst = 1'b1;
        #1;
        model_reset();
        model_compare();
        chk("arst_busy", int'(busy), 0);
        cycle();
        rst = 1'b0;
        n = 0; guard = 0;
        do begin
            cycle(); guard++;
            if (busy) n++;
        end while (!frame_done && guard < 200);
        chk("arst_refresh_frame", n, 80);

        // Randomized traffic checked by the model every cycle
        restart = 1'b1; cycle(); restart = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            enable  = ($urandom % 25) != 0;
            restart = ($urandom % 60) == 0;
            if ($urandom % 20 == 0) prescale = 6'($urandom_range(0, 12));
            if ($urandom % 20 == 0) data_bits = 4'($urandom_range(3, 11));
            if ($urandom % 10 == 0) par_en = 1'($urandom);
            if ($urandom % 10 == 0) two_stop = 1'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
